// File: rtl/baud_rate_gen_pkg.sv
// Shared constants for the UART baud/oversample tick generator: rate table,
// default widths and the reset divisor.
package baud_pkg;

  localparam int unsigned BAUD_DIV_W_DEF      = 32;
  localparam int unsigned BAUD_OVERSAMPLE_DEF = 16;
  localparam logic [31:0] BAUD_RESET_DIV      = 32'd868;

  localparam logic [31:0] BAUD_DIV_TABLE [0:7] = '{
    32'd868, 32'd1736, 32'd3472, 32'd6944,
    32'd111111, 32'd166666, 32'd1333333, 32'd2666666
  };

endpackage

// File: rtl/baud_rate_gen_frac_tick_div.sv
// Integer down-counter with fractional accumulator; emits one-cycle tick_os
// so that OVERSAMPLE consecutive periods add up exactly to the bit divisor.
module frac_tick_div #(
  parameter int unsigned INT_W  = 28,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              run,
  input  logic              suppress,
  input  logic [INT_W-1:0]  load_int,
  input  logic [INT_W-1:0]  int_div,
  input  logic [FRAC_W-1:0] frac,
  output logic              tick_due,
  output logic              tick_os
);

  localparam logic [INT_W-1:0] ONE = INT_W'(1);

  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              tick_q, tick_d;
  logic [FRAC_W-1:0] acc_sum;
  logic [FRAC_W:0]   acc_ahead;
  logic              carry;

  always_comb begin
    tick_due  = run && (cnt_q == '0);
    acc_sum   = acc_q + frac;
    // Carry looks one period ahead so every bit, including the first after a
    // load, contains exactly `frac` long periods.
    acc_ahead = {1'b0, acc_sum} + {1'b0, frac};
    carry     = acc_ahead[FRAC_W];

    cnt_d  = cnt_q;
    acc_d  = acc_q;
    tick_d = tick_due && !suppress && !clear;

    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (load) begin
      cnt_d = load_int - ONE;
      acc_d = '0;
    end else if (tick_due) begin
      cnt_d = int_div - ONE + {{(INT_W-1){1'b0}}, carry};
      acc_d = acc_sum;
    end else if (run) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_os = tick_q;

endmodule

// File: rtl/baud_rate_gen.sv
// Baud/oversample tick generator: divisor select, clamp, glitch-free apply at
// bit boundaries, bit tick. Optional `restart` port under BAUD_PHASE_RESTART_EN.
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W      = BAUD_DIV_W_DEF,
  parameter int unsigned OVERSAMPLE = BAUD_OVERSAMPLE_DEF,
  parameter int unsigned FRAC_W     = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef BAUD_PHASE_RESTART_EN
  input  logic             restart,
`endif
  input  logic             enable,
  input  logic [2:0]       rate_sel,
  input  logic             custom_en,
  input  logic             custom_div_wr,
  input  logic [DIV_W-1:0] custom_div,
  output logic             tick_os,
  output logic             tick_bit,
  output logic [DIV_W-1:0] active_div,
  output logic             div_pending,
  output logic             div_clamped
);

  localparam int unsigned       INT_W   = DIV_W - FRAC_W;
  localparam logic [DIV_W-1:0]  MIN_DIV = DIV_W'(2 * OVERSAMPLE);
  localparam logic [FRAC_W-1:0] OS_LAST = FRAC_W'(OVERSAMPLE - 1);
  localparam logic [FRAC_W-1:0] OS_ONE  = FRAC_W'(1);

  logic [DIV_W-1:0]  custom_q, custom_d;
  logic [DIV_W-1:0]  active_div_q, active_div_d;
  logic              div_clamped_q, div_clamped_d;
  logic              running_q, running_d;
  logic [FRAC_W-1:0] os_cnt_q, os_cnt_d;
  logic              tick_bit_q, tick_bit_d;

  logic [DIV_W-1:0]  sel_raw, sel_div, next_div;
  logic              clamp_hit, pending, start, bit_due, apply, load, restart_hit;
  logic              tick_due;

`ifdef BAUD_PHASE_RESTART_EN
  assign restart_hit = restart && running_q && enable;
`else
  assign restart_hit = 1'b0;
`endif

  always_comb begin
    sel_raw   = custom_en ? custom_q : DIV_W'(BAUD_DIV_TABLE[rate_sel]);
    clamp_hit = sel_raw < MIN_DIV;
    sel_div   = clamp_hit ? MIN_DIV : sel_raw;
    pending   = running_q && (sel_div != active_div_q);
    start     = enable && !running_q;
    bit_due   = tick_due && (os_cnt_q == OS_LAST) && !restart_hit;
    apply     = enable && pending && (bit_due || restart_hit);
    next_div  = apply ? sel_div : active_div_q;
    load      = start || apply || restart_hit;

    custom_d      = custom_div_wr ? custom_div : custom_q;
    active_div_d  = active_div_q;
    div_clamped_d = div_clamped_q;
    if (!enable || apply) begin
      active_div_d  = sel_div;
      div_clamped_d = clamp_hit;
    end

    running_d = enable;
    os_cnt_d  = os_cnt_q;
    if (!enable || start || restart_hit) begin
      os_cnt_d = '0;
    end else if (tick_due) begin
      os_cnt_d = os_cnt_q + OS_ONE;
    end
    tick_bit_d = enable && bit_due;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      custom_q      <= DIV_W'(BAUD_RESET_DIV);
      active_div_q  <= DIV_W'(BAUD_RESET_DIV);
      div_clamped_q <= 1'b0;
      running_q     <= 1'b0;
      os_cnt_q      <= '0;
      tick_bit_q    <= 1'b0;
    end else begin
      custom_q      <= custom_d;
      active_div_q  <= active_div_d;
      div_clamped_q <= div_clamped_d;
      running_q     <= running_d;
      os_cnt_q      <= os_cnt_d;
      tick_bit_q    <= tick_bit_d;
    end
  end

  frac_tick_div #(
    .INT_W (INT_W),
    .FRAC_W(FRAC_W)
  ) u_frac_tick_div (
    .clk     (clk),
    .reset   (reset),
    .clear   (!enable),
    .load    (load),
    .run     (running_q),
    .suppress(restart_hit),
    .load_int(next_div[DIV_W-1:FRAC_W]),
    .int_div (active_div_q[DIV_W-1:FRAC_W]),
    .frac    (active_div_q[FRAC_W-1:0]),
    .tick_due(tick_due),
    .tick_os (tick_os)
  );

  assign tick_bit    = tick_bit_q;
  assign active_div  = active_div_q;
  assign div_pending = pending;
  assign div_clamped = div_clamped_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen: directed scenarios plus random
// segments, compared every cycle against a period-schedule reference model.
module tb_baud_rate_gen;

  localparam int unsigned OS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  rate_sel = '0;
  logic        custom_en = 1'b0;
  logic        custom_div_wr = 1'b0;
  logic [31:0] custom_div = '0;
  logic        tick_os, tick_bit, div_pending, div_clamped;
  logic [31:0] active_div;
`ifdef BAUD_PHASE_RESTART_EN
  logic        restart = 1'b0;
`endif

  always #5 clk = ~clk;

  baud_rate_gen #(
    .DIV_W     (32),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef BAUD_PHASE_RESTART_EN
    .restart      (restart),
`endif
    .enable       (enable),
    .rate_sel     (rate_sel),
    .custom_en    (custom_en),
    .custom_div_wr(custom_div_wr),
    .custom_div   (custom_div),
    .tick_os      (tick_os),
    .tick_bit     (tick_bit),
    .active_div   (active_div),
    .div_pending  (div_pending),
    .div_clamped  (div_clamped)
  );

  int unsigned tbl [8] = '{868, 1736, 3472, 6944, 111111, 166666, 1333333, 2666666};

  bit          m_run, m_clamped, m_tos, m_tbit;
  int unsigned m_rem, m_os, m_act, m_custom;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Length of period j (1..OS) of a bit: long periods spread evenly, `frac` per bit.
  function automatic int unsigned ilen(input int unsigned d, input int unsigned j);
    int unsigned f;
    f = d % OS;
    return d / OS + (j * f) / OS - ((j - 1) * f) / OS;
  endfunction

  function automatic int unsigned raw_sel();
    return custom_en ? m_custom : tbl[rate_sel];
  endfunction

  function automatic int unsigned clampv(input int unsigned v);
    return (v < 2 * OS) ? 2 * OS : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_clamped = 0; m_tos = 0; m_tbit = 0;
    m_rem = 0; m_os = 0; m_act = 868; m_custom = 868;
  endtask

  task automatic model_edge();
    int unsigned raw, sel;
    bit cl;
    if (reset) begin
      model_reset();
      return;
    end
    raw = raw_sel();
    cl  = raw < 2 * OS;
    sel = clampv(raw);
    m_tos = 0; m_tbit = 0;
    if (!enable) begin
      m_run = 0; m_os = 0; m_act = sel; m_clamped = cl;
    end else if (!m_run) begin
      m_run = 1; m_os = 0; m_rem = ilen(m_act, 1);
    end
`ifdef BAUD_PHASE_RESTART_EN
    else if (restart) begin
      if (sel != m_act) begin m_act = sel; m_clamped = cl; end
      m_os = 0; m_rem = ilen(m_act, 1);
    end
`endif
    else begin
      m_rem--;
      if (m_rem == 0) begin
        m_tos = 1;
        m_os++;
        if (m_os == OS) begin
          m_os = 0; m_tbit = 1;
          if (sel != m_act) begin m_act = sel; m_clamped = cl; end
        end
        m_rem = ilen(m_act, m_os + 1);
      end
    end
    if (custom_div_wr) m_custom = custom_div;
  endtask

  task automatic compare_all();
    check_eq("tick_os", tick_os, m_tos);
    check_eq("tick_bit", tick_bit, m_tbit);
    check_eq("active_div", active_div, m_act);
    check_eq("div_clamped", div_clamped, m_clamped);
    check_eq("div_pending", div_pending, m_run && (clampv(raw_sel()) != m_act));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_flag(input bit want_bit, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(want_bit ? tick_bit : tick_os) && n < limit);
    check_eq(want_bit ? "wait_tick_bit" : "wait_tick_os", want_bit ? tick_bit : tick_os, 1);
  endtask

  initial begin
    int n, m, c109;
    bit seen;
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    repeat (3) step();

    // Table rate 0: first tick latency, period pattern, bit length.
    enable = 1'b1;
    step();
    wait_flag(0, 200, n); check_eq("first_os_gap", n, 54);
    wait_flag(0, 200, n); check_eq("os_gap2", n, 54);
    wait_flag(0, 200, n); check_eq("os_gap3", n, 54);
    wait_flag(0, 200, n); check_eq("os_gap4", n, 55);
    wait_flag(1, 2000, n);
    wait_flag(1, 2000, n); check_eq("bit_868", n, 868);

    // Mid-bit rate change waits for the boundary.
    repeat (300) step();
    rate_sel = 3'd1;
    step();
    check_eq("pending_mid", div_pending, 1);
    wait_flag(1, 2000, n); check_eq("old_bit_len", n + 301, 868);
    check_eq("new_active", active_div, 1736);
    wait_flag(1, 4000, n); check_eq("bit_1736", n, 1736);
    c109 = 0;
    for (int i = 0; i < 16; i++) begin
      wait_flag(0, 300, n);
      if (n == 109) c109++;
    end
    check_eq("long_periods", c109, 8);
    check_eq("bit_end_aligned", tick_bit, 1);

    // Custom divisor below minimum clamps to 2*OS.
    enable = 1'b0; custom_en = 1'b1; custom_div = 32'd20; custom_div_wr = 1'b1;
    step();
    custom_div_wr = 1'b0;
    step();
    check_eq("clamp_div", active_div, 32);
    check_eq("clamp_flag", div_clamped, 1);
    enable = 1'b1;
    step();
    wait_flag(0, 20, n); check_eq("clamp_os1", n, 2);
    wait_flag(0, 20, n); check_eq("clamp_os2", n, 2);
    wait_flag(1, 100, n);
    wait_flag(1, 100, n); check_eq("clamp_bit", n, 32);

    // Enable drop mid-bit.
    repeat (7) step();
    enable = 1'b0;
    seen = 0;
    repeat (10) begin step(); seen |= tick_os | tick_bit; end
    check_eq("idle_ticks", seen, 0);
    enable = 1'b1;
    step();
    wait_flag(0, 20, n); check_eq("reen_os", n, 2);

    // Asynchronous reset mid-bit at rate 3.
    custom_en = 1'b0; rate_sel = 3'd3; enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (2000) step();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_tick_os", tick_os, 0);
    check_eq("rst_tick_bit", tick_bit, 0);
    check_eq("rst_active", active_div, 868);
    check_eq("rst_pending", div_pending, 0);
    check_eq("rst_clamped", div_clamped, 0);
    model_reset();
    step();
    reset = 1'b0;
    enable = 1'b0;
    rate_sel = 3'd0;
    step();

`ifdef BAUD_PHASE_RESTART_EN
    enable = 1'b1;
    step();
    wait_flag(1, 2000, n);
    repeat (300) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_eq("restart_no_tick", tick_os, 0);
    wait_flag(0, 200, n); check_eq("restart_os", n, 54);
    wait_flag(1, 2000, m); check_eq("restart_bit", n + m, 868);
`endif

    // Random segments.
    for (int s = 0; s < 40; s++) begin
      enable    = ($urandom_range(0, 7) != 0);
      custom_en = $urandom_range(0, 1);
      rate_sel  = custom_en ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      n = $urandom_range(1, 700);
      for (int k = 0; k < n; k++) begin
        custom_div_wr = ($urandom_range(0, 150) == 0) || (k == 0 && $urandom_range(0, 2) == 0);
        if (custom_div_wr) custom_div = $urandom_range(8, 600);
`ifdef BAUD_PHASE_RESTART_EN
        restart = ($urandom_range(0, 300) == 0);
`endif
        step();
      end
      custom_div_wr = 1'b0;
`ifdef BAUD_PHASE_RESTART_EN
      restart = 1'b0;
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
